// File: rtl/fetch_unit.sv
// fetch_unit: front end of the 2-slot VLIW pipeline.
//   Owns the PC, fetches 64-bit bundles over a req/valid handshake and drives the IF/ID (p1)
//   register. Applies the pcSrc/IF_flush redirect commands and captures epc on pcSrc=3.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   pcSrc                 0=sequential 1=branch 2=jump 3=exception vector
//   IF_flush, stall       squash p1 / decode cannot accept a new bundle
//   branchTarget          redirect address for pcSrc=1
//   jumpTarget            redirect address for pcSrc=2
//   imem_req, imem_addr   fetch request and address
//   imem_valid            imem_rdata valid (only meaningful while imem_req=1)
//   imem_rdata            bundle: [63:32] ALU slot, [31:0] MEM slot
//   p1_bundle, p1_pc      bundle presented to decode and its address
//   p1_valid              p1_bundle is live (0 = NOP)
//   epc                   p1_pc sampled on the last pcSrc=3 redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
  parameter int unsigned BUNDLE_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pcSrc,
  input  logic        IF_flush,
  input  logic        stall,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [63:0] imem_rdata,
  output logic [63:0] p1_bundle,
  output logic [31:0] p1_pc,
  output logic        p1_valid,
  output logic [31:0] epc
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StDrop  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [1:0]  stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic [31:0] reqAddrQ, reqAddrD;   // address of an in-flight request being dropped
  logic [63:0] holdBundleQ, holdBundleD;
  logic [31:0] holdPcQ, holdPcD;
  logic [63:0] p1BundleD;
  logic [31:0] p1PcD;
  logic        p1ValidD;
  logic [31:0] epcD;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcInc;
  logic        canAdvance;
  logic        p1Load;
  logic [63:0] p1LoadBundle;
  logic [31:0] p1LoadPc;

  assign redirect   = (pcSrc != 2'd0);
  assign pcInc      = pcQ + 32'(BUNDLE_BYTES);
  // Decode takes a new bundle unless it is stalled on a live one.
  assign canAdvance = !stall || !p1_valid;

  always_comb begin
    unique case (pcSrc)
      2'd1:    target = branchTarget;
      2'd2:    target = jumpTarget;
      2'd3:    target = EXC_VECTOR;
      default: target = pcQ;
    endcase
  end

  assign imem_req  = (stateQ == StFetch) || (stateQ == StDrop);
  // In DROP the abandoned request keeps its original address until it completes.
  assign imem_addr = (stateQ == StDrop) ? reqAddrQ : pcQ;

  always_comb begin
    stateD       = stateQ;
    pcD          = pcQ;
    reqAddrD     = reqAddrQ;
    holdBundleD  = holdBundleQ;
    holdPcD      = holdPcQ;
    epcD         = epc;
    p1Load       = 1'b0;
    p1LoadBundle = imem_rdata;
    p1LoadPc     = pcQ;

    case (stateQ)
      StIdle: stateD = StFetch;
      StFetch: begin
        if (imem_valid) begin
          if (!redirect) begin
            pcD = pcInc;
            if (canAdvance) begin
              p1Load = 1'b1;
            end else begin
              holdBundleD = imem_rdata;
              holdPcD     = pcQ;
              stateD      = StHold;
            end
          end
        end else if (redirect) begin
          reqAddrD = pcQ;
          stateD   = StDrop;
        end
      end
      StDrop: begin
        if (imem_valid) stateD = StFetch;
      end
      StHold: begin
        if (redirect) begin
          stateD = StFetch;
        end else if (canAdvance && !IF_flush) begin
          p1Load       = 1'b1;
          p1LoadBundle = holdBundleQ;
          p1LoadPc     = holdPcQ;
          stateD       = StFetch;
        end
      end
      default: stateD = StIdle;
    endcase

    // Redirect target always overrides the sequential pc; the latest redirect wins.
    if (redirect) begin
      pcD = target;
      if (pcSrc == 2'd3) epcD = p1_pc;
    end
  end

  always_comb begin
    p1BundleD = p1_bundle;
    p1PcD     = p1_pc;
    p1ValidD  = p1_valid;
    if (IF_flush) begin
      p1BundleD = 64'd0;
      p1ValidD  = 1'b0;
    end else if (p1Load) begin
      p1BundleD = p1LoadBundle;
      p1PcD     = p1LoadPc;
      p1ValidD  = 1'b1;
    end else if (canAdvance) begin
      p1BundleD = 64'd0;
      p1ValidD  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= StIdle;
      pcQ         <= RESET_PC;
      reqAddrQ    <= 32'd0;
      holdBundleQ <= 64'd0;
      holdPcQ     <= 32'd0;
      p1_bundle   <= 64'd0;
      p1_pc       <= 32'd0;
      p1_valid    <= 1'b0;
      epc         <= 32'd0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      reqAddrQ    <= reqAddrD;
      holdBundleQ <= holdBundleD;
      holdPcQ     <= holdPcD;
      p1_bundle   <= p1BundleD;
      p1_pc       <= p1PcD;
      p1_valid    <= p1ValidD;
      epc         <= epcD;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pcSrc;
  logic        IF_flush;
  logic        stall;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [63:0] imem_rdata;
  logic [63:0] p1_bundle;
  logic [31:0] p1_pc;
  logic        p1_valid;
  logic [31:0] epc;

  int total = 0;
  int bad   = 0;

  // Instruction memory model state
  int latency = 0;
  bit randLat = 1'b0;
  int waitCnt = 0;
  bit reqSeen = 1'b0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pcSrc        (pcSrc),
    .IF_flush     (IF_flush),
    .stall        (stall),
    .branchTarget (branchTarget),
    .jumpTarget   (jumpTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .p1_bundle    (p1_bundle),
    .p1_pc        (p1_pc),
    .p1_valid     (p1_valid),
    .epc          (epc)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tag(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Memory answers `latency` cycles after a request starts; data is tagged with its address.
  always @(negedge clk) begin
    if (reset) begin
      waitCnt    = 0;
      reqSeen    = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = 64'd0;
    end else begin
      if (reqSeen) begin
        if (imem_valid) begin
          waitCnt = 0;
          if (randLat) latency = $urandom_range(0, 3);
        end else begin
          waitCnt++;
        end
      end
      reqSeen    = imem_req;
      imem_valid = imem_req && (waitCnt >= latency);
      imem_rdata = tag(imem_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clearInputs();
    pcSrc        = 2'd0;
    IF_flush     = 1'b0;
    stall        = 1'b0;
    branchTarget = 32'd0;
    jumpTarget   = 32'd0;
  endtask

  task automatic applyReset(input int lat);
    clearInputs();
    latency = lat;
    randLat = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (imem_req !== 1'b0 || p1_valid !== 1'b0 || p1_pc !== 32'd0 || p1_bundle !== 64'd0 ||
        epc !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: req=%b p1_valid=%b p1_pc=%h p1_bundle=%h epc=%h expected all 0",
               imem_req, p1_valid, p1_pc, p1_bundle, epc);
    end
    reset = 1'b0;
    tick();  // first clock after reset: IDLE -> FETCH
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL first_fetch: req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  // T1: one bundle per cycle with zero-latency memory
  task automatic test_stream();
    applyReset(0);
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(8 * i)) begin
        bad++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h expected req=1 addr=%h",
                 i, imem_req, imem_addr, 32'(8 * i));
      end
      if (i > 0) begin
        total++;
        if (p1_valid !== 1'b1 || p1_pc !== 32'(8 * (i - 1)) ||
            p1_bundle !== tag(32'(8 * (i - 1)))) begin
          bad++;
          $display("FAIL stream_p1[%0d]: valid=%b pc=%h bundle=%h expected valid=1 pc=%h",
                   i, p1_valid, p1_pc, p1_bundle, 32'(8 * (i - 1)));
        end
      end
    end
  endtask

  // T2: stall three cycles with p1_pc=8; bundle 16 parks in hold
  task automatic test_stall();
    applyReset(0);
    tick();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (imem_req !== 1'b0 || p1_valid !== 1'b1 || p1_pc !== 32'h8) begin
        bad++;
        $display("FAIL stall_hold[%0d]: req=%b valid=%b pc=%h expected req=0 valid=1 pc=8",
                 i, imem_req, p1_valid, p1_pc);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (p1_valid !== 1'b1 || p1_pc !== 32'h10 || p1_bundle !== tag(32'h10) ||
        imem_req !== 1'b1 || imem_addr !== 32'h18) begin
      bad++;
      $display("FAIL stall_release: valid=%b pc=%h req=%b addr=%h expected 1 10 1 18",
               p1_valid, p1_pc, imem_req, imem_addr);
    end
    tick();
    total++;
    if (p1_valid !== 1'b1 || p1_pc !== 32'h18) begin
      bad++;
      $display("FAIL stall_after: valid=%b pc=%h expected valid=1 pc=18", p1_valid, p1_pc);
    end
  endtask

  // T3: branch with flush while p1_pc=0x10
  task automatic test_branch_flush();
    applyReset(0);
    repeat (4) tick();
    pcSrc        = 2'd1;
    branchTarget = 32'h40;
    IF_flush     = 1'b1;
    tick();
    clearInputs();
    total++;
    if (p1_valid !== 1'b0 || p1_bundle !== 64'd0 || imem_addr !== 32'h40) begin
      bad++;
      $display("FAIL branch_flush: valid=%b bundle=%h addr=%h expected 0 0 40",
               p1_valid, p1_bundle, imem_addr);
    end
    tick();
    total++;
    if (p1_valid !== 1'b1 || p1_pc !== 32'h40 || p1_bundle !== tag(32'h40)) begin
      bad++;
      $display("FAIL branch_target: valid=%b pc=%h expected valid=1 pc=40", p1_valid, p1_pc);
    end
  endtask

  // T4: jump in the first cycle of a slow request; the old response is dropped
  task automatic test_drop();
    bit seen;
    applyReset(3);
    tick();
    pcSrc      = 2'd2;
    jumpTarget = 32'h80;
    tick();
    clearInputs();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        bad++;
        $display("FAIL drop_addr[%0d]: req=%b addr=%h expected req=1 addr=0",
                 i, imem_req, imem_addr);
      end
      tick();
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80 || p1_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_redirect: req=%b addr=%h valid=%b expected 1 80 0",
               imem_req, imem_addr, p1_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (p1_valid) seen = 1'b1;
    end
    total++;
    if (!seen || p1_pc !== 32'h80 || p1_bundle !== tag(32'h80)) begin
      bad++;
      $display("FAIL drop_first_bundle: seen=%b pc=%h expected seen=1 pc=80", seen, p1_pc);
    end
  endtask

  // T5: exception redirect with flush and stall at p1_pc=0x24
  task automatic test_exception();
    applyReset(0);
    tick();
    pcSrc      = 2'd2;
    jumpTarget = 32'h24;
    tick();
    clearInputs();
    tick();
    pcSrc    = 2'd3;
    IF_flush = 1'b1;
    stall    = 1'b1;
    tick();
    clearInputs();
    total++;
    if (epc !== 32'h24 || p1_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL exception: epc=%h valid=%b req=%b addr=%h expected 24 0 1 100",
               epc, p1_valid, imem_req, imem_addr);
    end
    tick();
    total++;
    if (p1_valid !== 1'b1 || p1_pc !== 32'h100) begin
      bad++;
      $display("FAIL exception_resume: valid=%b pc=%h expected valid=1 pc=100", p1_valid, p1_pc);
    end
  endtask

  // T6: pc wraps, then reset in the middle of a dropped request
  task automatic test_wrap_and_reset();
    applyReset(0);
    tick();
    pcSrc      = 2'd2;
    jumpTarget = 32'hFFFF_FFF8;
    tick();
    clearInputs();
    tick();
    total++;
    if (imem_addr !== 32'h0 || p1_pc !== 32'hFFFF_FFF8) begin
      bad++;
      $display("FAIL wrap: addr=%h p1_pc=%h expected addr=0 p1_pc=fffffff8", imem_addr, p1_pc);
    end
    applyReset(3);
    tick();
    pcSrc      = 2'd2;
    jumpTarget = 32'h80;
    tick();
    clearInputs();
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || p1_valid !== 1'b0 || epc !== 32'd0) begin
      bad++;
      $display("FAIL reset_in_drop: req=%b valid=%b epc=%h expected 0 0 0", imem_req, p1_valid, epc);
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_refetch: req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
    for (int i = 0; i < 12 && !p1_valid; i++) tick();
    total++;
    if (p1_valid !== 1'b1 || p1_pc !== 32'h0 || p1_bundle !== tag(32'h0)) begin
      bad++;
      $display("FAIL reset_first_bundle: valid=%b pc=%h expected valid=1 pc=0", p1_valid, p1_pc);
    end
  endtask

  // Random latency and stalls: decode must see 0,8,16,... exactly once each, in order.
  task automatic test_random();
    logic [31:0] expPc;
    int          consumed;
    bit          newStall, prevValid, prevStall, prevReq, prevMemValid;
    logic [31:0] prevPc, prevAddr;
    applyReset($urandom_range(0, 3));
    randLat   = 1'b1;
    expPc     = 32'd0;
    consumed  = 0;
    prevValid = 1'b0;
    prevStall = 1'b0;
    prevReq   = 1'b0;
    prevMemValid = 1'b0;
    prevPc    = 32'd0;
    prevAddr  = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (prevValid && prevStall) begin
        total++;
        if (p1_valid !== 1'b1 || p1_pc !== prevPc) begin
          bad++;
          $display("FAIL rand_stall_hold[%0d]: valid=%b pc=%h expected valid=1 pc=%h",
                   cyc, p1_valid, p1_pc, prevPc);
        end
      end
      if (prevReq && !prevMemValid && imem_req) begin
        total++;
        if (imem_addr !== prevAddr) begin
          bad++;
          $display("FAIL rand_addr_stable[%0d]: addr=%h expected %h", cyc, imem_addr, prevAddr);
        end
      end
      newStall = ($urandom_range(0, 9) < 3);
      if (p1_valid && !newStall) begin
        total++;
        if (p1_pc !== expPc || p1_bundle !== tag(expPc)) begin
          bad++;
          $display("FAIL rand_order[%0d]: pc=%h bundle=%h expected pc=%h", cyc, p1_pc, p1_bundle,
                   expPc);
        end
        expPc = expPc + 32'd8;
        consumed++;
      end
      stall        = newStall;
      prevValid    = p1_valid;
      prevStall    = newStall;
      prevPc       = p1_pc;
      prevReq      = imem_req;
      prevMemValid = imem_valid;
      prevAddr     = imem_addr;
    end
    stall   = 1'b0;
    randLat = 1'b0;
    total++;
    if (consumed < 50) begin
      bad++;
      $display("FAIL rand_progress: consumed=%0d expected at least 50", consumed);
    end
  endtask

  initial begin
    reset      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 64'd0;
    clearInputs();
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_drop();
    test_exception();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
